// File: rtl/tick_sched_ctrl.sv
`timescale 1ns/1ps
// tick_sched_ctrl
//   Programmable clock-enable scheduler. One synchronous divide counter on clk
//   produces a registered one-cycle tick every div_reg cycles and advances a
//   round-robin slot index (plus its one-hot decode) on every tick. The divide
//   ratio is changed through a valid/ready handshake. While running, a new
//   ratio is held pending and only takes effect on the next terminal count, so
//   the tick period never glitches.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   start        level; IDLE -> RUN when high and stop low
//   stop         level; RUN/RELOAD -> IDLE, wins over start and terminal count
//   cfg_valid    new divide ratio offered on cfg_div
//   cfg_div      divide ratio (0 is treated as 1)
//   cfg_ready    ratio can be accepted this cycle (low while a ratio is pending)
//   tick         registered one-cycle enable pulse
//   slot         current consumer index
//   slot_onehot  registered one-hot decode of slot
//   busy         registered, high in RUN or RELOAD
module tick_sched_ctrl #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DEFAULT_DIV = 50000,
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned SLOT_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 cfg_valid,
    input  logic [CNT_W-1:0]     cfg_div,
    output logic                 cfg_ready,
    output logic                 tick,
    output logic [SLOT_W-1:0]    slot,
    output logic [NUM_SLOTS-1:0] slot_onehot,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [CNT_W-1:0]       div_reg, div_n;
    logic [CNT_W-1:0]       pend_div, pend_n;
    logic                   tick_n;
    logic                   busy_n;
    logic [SLOT_W-1:0]      slot_n;
    logic [NUM_SLOTS-1:0]   onehot_n;

    logic                   accept;
    logic                   term;
    logic [CNT_W-1:0]       cfg_div_eff;
    logic [SLOT_W-1:0]      slot_inc;

    assign cfg_ready   = (state != RELOAD);
    assign accept      = cfg_valid & cfg_ready;
    assign cfg_div_eff = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    // div_reg is never 0, so div_reg-1 cannot underflow.
    assign term        = (cnt == div_reg - CNT_W'(1));
    assign slot_inc    = (slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot + SLOT_W'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = div_reg;
        pend_n  = pend_div;
        tick_n  = 1'b0;
        slot_n  = slot;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    div_n = cfg_div_eff;
                end
                if (start && !stop) begin
                    state_n = RUN;
                end
            end

            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    // A ratio offered on the stopping edge is not lost.
                    if (accept) begin
                        div_n = cfg_div_eff;
                    end
                end else begin
                    if (term) begin
                        cnt_n  = '0;
                        tick_n = 1'b1;
                        slot_n = slot_inc;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                    // Still finishes the current period with the old ratio.
                    if (accept) begin
                        pend_n  = cfg_div_eff;
                        state_n = RELOAD;
                    end
                end
            end

            RELOAD: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    div_n   = pend_div;
                end else if (term) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    tick_n  = 1'b1;
                    slot_n  = slot_inc;
                    div_n   = pend_div;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        onehot_n         = '0;
        onehot_n[slot_n] = 1'b1;
        busy_n           = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_reg     <= CNT_W'(DEFAULT_DIV);
            pend_div    <= '0;
            tick        <= 1'b0;
            slot        <= '0;
            slot_onehot <= NUM_SLOTS'(1);
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            div_reg     <= div_n;
            pend_div    <= pend_n;
            tick        <= tick_n;
            slot        <= slot_n;
            slot_onehot <= onehot_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_tick_sched_ctrl.sv
`timescale 1ns/1ps
// Bench for tick_sched_ctrl: per-cycle stimulus/expectation table plus a
// hand-written asynchronous reset sequence. Expected outputs are queued when
// the stimulus is driven and compared one cycle later.
module tb_tick_sched_ctrl;

    localparam int unsigned CNT_W     = 20;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned DEF_DIV   = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 stop;
    logic                 cfg_valid;
    logic [CNT_W-1:0]     cfg_div;
    logic                 cfg_ready;
    logic                 tick;
    logic [SLOT_W-1:0]    slot;
    logic [NUM_SLOTS-1:0] slot_onehot;
    logic                 busy;

    always #5 clk = ~clk;

    tick_sched_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEF_DIV),
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_W     (SLOT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .tick       (tick),
        .slot       (slot),
        .slot_onehot(slot_onehot),
        .busy       (busy)
    );

    typedef struct {
        logic             start;
        logic             stop;
        logic             cv;
        logic [CNT_W-1:0] cd;
        logic             e_tick;
        int unsigned      e_slot;
        logic             e_busy;
        logic             e_ready;
    } vec_t;

    typedef struct {
        logic        tick;
        int unsigned slot;
        logic        busy;
        logic        ready;
        int unsigned id;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned s        = 0;   // expected slot while building sequences

    function automatic vec_t mk(input logic st, input logic sp, input logic cv,
                                input int unsigned cd, input logic et,
                                input int unsigned es, input logic eb,
                                input logic er);
        vec_t r;
        r.start   = st;
        r.stop    = sp;
        r.cv      = cv;
        r.cd      = CNT_W'(cd);
        r.e_tick  = et;
        r.e_slot  = es;
        r.e_busy  = eb;
        r.e_ready = er;
        return r;
    endfunction

    function automatic void add(input logic st, input logic sp, input logic cv,
                                input int unsigned cd, input logic et,
                                input int unsigned es, input logic eb,
                                input logic er);
        vecs.push_back(mk(st, sp, cv, cd, et, es, eb, er));
    endfunction

    task automatic check(input string name, input int unsigned id,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (vec %0d): got %0h expected %0h", name, id, act, exp);
    endtask

    task automatic compare_out();
        exp_t                 e;
        logic [NUM_SLOTS-1:0] oh;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e       = sb.pop_front();
            oh      = '0;
            oh[e.slot] = 1'b1;
            check("tick",        e.id, 32'(tick),        32'(e.tick));
            check("slot",        e.id, 32'(slot),        e.slot);
            check("slot_onehot", e.id, 32'(slot_onehot), 32'(oh));
            check("busy",        e.id, 32'(busy),        32'(e.busy));
            check("cfg_ready",   e.id, 32'(cfg_ready),   32'(e.ready));
        end
    endtask

    task automatic drive(input vec_t v, input int unsigned id);
        exp_t e;
        start     = v.start;
        stop      = v.stop;
        cfg_valid = v.cv;
        cfg_div   = v.cd;
        e.tick    = v.e_tick;
        e.slot    = v.e_slot;
        e.busy    = v.e_busy;
        e.ready   = v.e_ready;
        e.id      = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timed out");
    end

    initial begin
        int unsigned t6_vals[4] = '{6, 2, 0, 3};
        logic        tk;
        exp_t        r;

        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;

        // Divide 5 set in IDLE, ticks 5/10/15/20 after start, slot 1,2,3,0.
        add(0, 0, 1, 5, 0, s, 0, 1);
        add(1, 0, 0, 0, 0, s, 1, 1);
        for (int k = 1; k <= 20; k++) begin
            tk = (k % 5 == 0);
            if (tk) s = (s + 1) % NUM_SLOTS;
            add(0, 0, 0, 0, tk, s, 1, 1);
        end
        add(0, 1, 0, 0, 0, s, 0, 1);

        // Divide 1, configured once as 0 and once as 1: tick every cycle.
        // The stop edge is a terminal count, so no tick there.
        for (int d = 0; d <= 1; d++) begin
            add(1, 0, 1, d, 0, s, 1, 1);
            for (int k = 1; k <= 6; k++) begin
                s = (s + 1) % NUM_SLOTS;
                add(0, 0, 0, 0, 1, s, 1, 1);
            end
            add(0, 1, 0, 0, 0, s, 0, 1);
        end

        // Divide 8, ratio 3 accepted at cycle 11; offer of 7 at cycle 13 is
        // ignored while pending. Ticks at 8, 16, then every 3 cycles.
        add(0, 0, 1, 8, 0, s, 0, 1);
        add(1, 0, 0, 0, 0, s, 1, 1);
        for (int k = 1; k <= 22; k++) begin
            tk = (k == 8) || (k == 16) || (k == 19) || (k == 22);
            if (tk) s = (s + 1) % NUM_SLOTS;
            add(0, 0, (k == 11) || (k == 13), (k == 11) ? 3 : 7, tk, s, 1,
                !(k >= 11 && k <= 15));
        end
        add(0, 1, 0, 0, 0, s, 0, 1);

        // Divide 4, stop on the terminal-count edge, then restart.
        add(0, 0, 1, 4, 0, s, 0, 1);
        add(1, 0, 0, 0, 0, s, 1, 1);
        for (int k = 1; k <= 7; k++) begin
            tk = (k == 4);
            if (tk) s = (s + 1) % NUM_SLOTS;
            add(0, 0, 0, 0, tk, s, 1, 1);
        end
        add(0, 1, 0, 0, 0, s, 0, 1);
        add(0, 0, 0, 0, 0, s, 0, 1);
        add(1, 0, 0, 0, 0, s, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            tk = (k == 4);
            if (tk) s = (s + 1) % NUM_SLOTS;
            add(0, 0, 0, 0, tk, s, 1, 1);
        end
        add(0, 1, 0, 0, 0, s, 0, 1);

        // start&stop together stays IDLE; every offered ratio is accepted,
        // the last one (3) sets the period once started.
        for (int i = 0; i < 4; i++) begin
            add(1, 1, 1, t6_vals[i], 0, s, 0, 1);
        end
        add(1, 0, 0, 0, 0, s, 1, 1);
        for (int k = 1; k <= 6; k++) begin
            tk = (k % 3 == 0);
            if (tk) s = (s + 1) % NUM_SLOTS;
            add(0, 0, 0, 0, tk, s, 1, 1);
        end
        add(0, 1, 0, 0, 0, s, 0, 1);

        // Reset state, checked while rst is held.
        #12;
        r.tick  = 1'b0;
        r.slot  = 0;
        r.busy  = 1'b0;
        r.ready = 1'b1;
        r.id    = 0;
        sb.push_back(r);
        compare_out();
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i], 32'(i + 1));
        end

        // Async reset mid-RUN at divide 1 (tick high), off the clock edge.
        drive(mk(1, 0, 1, 0, 0, s, 1, 1), 1000);
        for (int k = 1; k <= 3; k++) begin
            s = (s + 1) % NUM_SLOTS;
            drive(mk(0, 0, 0, 0, 1, s, 1, 1), 32'(1000 + k));
        end
        #2 rst = 1'b1;
        r.tick  = 1'b0;
        r.slot  = 0;
        r.busy  = 1'b0;
        r.ready = 1'b1;
        r.id    = 1100;
        sb.push_back(r);
        #1;
        compare_out();
        #2 rst = 1'b0;

        // Divide ratio is back to the reset default.
        s = 0;
        drive(mk(1, 0, 0, 0, 0, s, 1, 1), 1200);
        for (int k = 1; k <= int'(DEF_DIV) + 1; k++) begin
            tk = (k == int'(DEF_DIV));
            if (tk) s = (s + 1) % NUM_SLOTS;
            drive(mk(0, 0, 0, 0, tk, s, 1, 1), 32'(1200 + k));
        end
        drive(mk(0, 1, 0, 0, 0, s, 0, 1), 1300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
